ise_sort_sched: RTL and testbench
=================================

# ise_sort_sched

Output scheduler for the Image Sorting Engine (ISE). It collects one classification record per image (dominant colour index plus a dominance key) from the per-image statistics datapath and stores them in a NUM-entry table. Once every image slot is filled, it runs an iterative selection scan over the table. It then streams the sorted sequence to the ISE output port (`out_valid`, `color_index`, `image_out_index`).

## Interface

**Parameters**
- `NUM`, default 32: number of images per sort run (table depth).
- `IDX_W`, default 5: image index width; 2^IDX_W ≥ NUM.
- `KEY_W`, default 15: dominance key width (pixel count, 0..16384).

**Ports**
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: synchronous reset, active high.
- `rec_valid`, input, 1: record strobe from the statistics datapath.
- `rec_index`, input, IDX_W: image index of the record.
- `rec_color`, input, 2: dominant colour (0=R, 1=G, 2=B; 3 is legal and sorts last).
- `rec_key`, input, KEY_W: dominance key.
- `rec_ready`, output, 1: high only in LOAD; records are accepted when `rec_valid && rec_ready`.
- `busy`, output, 1: high in SCAN and EMIT; feeds the ISE `busy` output.
- `out_valid`, output, 1: one-cycle pulse per sorted output.
- `color_index`, output, 2: colour of the emitted image; meaningful only while `out_valid` is high.
- `image_out_index`, output, IDX_W: index of the emitted image.
- `sort_done`, output, 1: one-cycle pulse coinciding with the NUM-th `out_valid`.

## Operation

**Table contents**
- Per entry: `color[1:0]`, `key[KEY_W-1:0]`, `vld`, `used`.

**LOAD state**
- An accepted record writes entry `rec_index` and sets its `vld`.
- A duplicate index overwrites colour and key; the fill count is unchanged.
- A record with `rec_index` ≥ NUM is ignored.
- When the accepted record makes the count of set `vld` bits equal NUM, the block moves to SCAN at that edge.

**SCAN state**
- A pointer walks entries 0..NUM-1, one entry per cycle, skipping entries with `used` set.
- Each examined entry is compared against the best candidate so far. The entry replaces the best only if it is strictly better:
  - lower colour wins;
  - on equal colour, higher key wins.
- Ties therefore resolve to the lowest image index.
- After entry NUM-1 has been examined, the block moves to EMIT.

**EMIT state** (one cycle)
- `out_valid`=1, with `color_index` and `image_out_index` taken from the best candidate.
- The best entry's `used` bit is set.
- If this is the NUM-th emission: `sort_done`=1, all `vld` and `used` bits are cleared, and the next state is LOAD.
- Otherwise the best candidate is cleared and the next state is SCAN.

**Records outside LOAD**
- `rec_valid` asserted while not in LOAD is dropped without side effects.

**Reset**
- Applies at any point, including mid-SCAN or mid-EMIT.
- Clears all `vld`/`used` bits, the pointer and the best candidate, and sets state to LOAD.
- No partial output sequence continues after reset.

## Timing

**Output values**
- Values after reset: `out_valid`=0, `sort_done`=0, `busy`=0, `color_index`=0, `image_out_index`=0, `rec_ready`=1.
- `busy` and `rec_ready` are decoded from the state register: no combinational path from `rec_valid`.
- `color_index` and `image_out_index` hold their last emitted value between pulses.

**Latency**
- Let E0 be the edge that accepts the last record. SCAN examines entries on edges E1..E_NUM.
- The first `out_valid` is high in the cycle after edge E_NUM, i.e. NUM+1 cycles after E0 (33 cycles at defaults).
- Successive `out_valid` pulses are exactly NUM+1 cycles apart.
- A full run takes NUM·(NUM+1) cycles from E0 to the final pulse (1056 at defaults).

**Return to LOAD**
- `rec_ready` rises in the cycle after the `sort_done` pulse.
- A record presented in that cycle is accepted.

## Test plan

1. **Full sort.** Load indices 0..31 in order with colour = i%3 and key = i*100. Required: 32 pulses, 33 cycles apart.
   - Order: colour 0 first by descending key (30, 27, …, 0), then colour 1 (31, 28, …, 1), then colour 2 (29, …, 2).
   - `sort_done` coincides with the pulse for index 2.
2. **Tie-break.** All 32 records have colour 1 and key 500, loaded in reverse index order. Required: output indices 0, 1, …, 31.
3. **Duplicate index.** Send index 5 twice (keys 10 then 9000), then the remaining 31 indices, all colour 0 with keys < 9000. Required: sorting starts only after all 32 distinct indices are present, and index 5 is emitted first with colour 0.
4. **Dropped record.** During SCAN, drive `rec_valid` with index 7, colour 3. Required: the table is unchanged and the output for index 7 carries its original colour.
5. **Colour 3 ordering.** Index 0 has colour 3 and key max; all others have colour 2. Required: index 0 is emitted last.
6. **Reset mid-run.** Assert `reset` for one cycle after the 10th `out_valid`. Required:
   - no further `out_valid`, and `rec_ready`=1 on the next cycle;
   - a fresh 32-record load produces a complete, correct 32-output sequence.

Source files
------------

// File: rtl/ise_sort_sched.sv
// ISE output scheduler: collects one colour/key record per image, then emits images
// in (colour ascending, key descending, index ascending) order via repeated selection scans.
module ise_sort_sched #(
    parameter int NUM   = 32,
    parameter int IDX_W = 5,
    parameter int KEY_W = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rec_valid,
    input  logic [IDX_W-1:0] rec_index,
    input  logic [1:0]       rec_color,
    input  logic [KEY_W-1:0] rec_key,
    output logic             rec_ready,
    output logic             busy,
    output logic             out_valid,
    output logic [1:0]       color_index,
    output logic [IDX_W-1:0] image_out_index,
    output logic             sort_done
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [IDX_W:0]   NUM_CNT  = (IDX_W+1)'(NUM);
    localparam logic [IDX_W:0]   LAST_CNT = (IDX_W+1)'(NUM - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

    state_t state, state_nxt;

    logic [1:0]       color_tab [NUM];
    logic [KEY_W-1:0] key_tab   [NUM];
    logic [NUM-1:0]   vld;
    logic [NUM-1:0]   used;

    logic [IDX_W:0]   fill_cnt;
    logic [IDX_W:0]   emit_cnt;
    logic [IDX_W-1:0] ptr;

    logic             best_vld;
    logic [1:0]       best_color;
    logic [KEY_W-1:0] best_key;
    logic [IDX_W-1:0] best_idx;

    logic             accept;
    logic             new_entry;
    logic             fill_full;
    logic             last_emit;
    logic             take;
    logic             nb_vld;
    logic [1:0]       nb_color;
    logic [KEY_W-1:0] nb_key;
    logic [IDX_W-1:0] nb_idx;

    assign rec_ready = (state == LOAD);
    assign busy      = (state != LOAD);

    assign accept    = (state == LOAD) && rec_valid && ({1'b0, rec_index} < NUM_CNT);
    assign new_entry = accept && !vld[rec_index];
    assign fill_full = new_entry && (fill_cnt == LAST_CNT);
    assign last_emit = (emit_cnt == LAST_CNT);

    // Strict improvement only, so an equal entry never displaces an earlier (lower) index.
    always_comb begin
        take     = 1'b0;
        nb_vld   = best_vld;
        nb_color = best_color;
        nb_key   = best_key;
        nb_idx   = best_idx;
        if (state == SCAN && !used[ptr]) begin
            take = !best_vld
                || (color_tab[ptr] < best_color)
                || ((color_tab[ptr] == best_color) && (key_tab[ptr] > best_key));
        end
        if (take) begin
            nb_vld   = 1'b1;
            nb_color = color_tab[ptr];
            nb_key   = key_tab[ptr];
            nb_idx   = ptr;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (fill_full) state_nxt = SCAN;
            SCAN:    if (ptr == LAST_IDX) state_nxt = EMIT;
            EMIT:    state_nxt = last_emit ? LOAD : SCAN;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            color_tab[rec_index] <= rec_color;
            key_tab[rec_index]   <= rec_key;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld             <= '0;
            used            <= '0;
            fill_cnt        <= '0;
            emit_cnt        <= '0;
            ptr             <= '0;
            best_vld        <= 1'b0;
            best_color      <= '0;
            best_key        <= '0;
            best_idx        <= '0;
            out_valid       <= 1'b0;
            sort_done       <= 1'b0;
            color_index     <= '0;
            image_out_index <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        vld[rec_index] <= 1'b1;
                        if (new_entry) fill_cnt <= fill_cnt + (IDX_W+1)'(1);
                    end
                end
                SCAN: begin
                    best_vld   <= nb_vld;
                    best_color <= nb_color;
                    best_key   <= nb_key;
                    best_idx   <= nb_idx;
                    // Output registers load on the final examine edge so the pulse lands in EMIT.
                    if (ptr == LAST_IDX) begin
                        ptr             <= '0;
                        out_valid       <= 1'b1;
                        sort_done       <= last_emit;
                        color_index     <= nb_color;
                        image_out_index <= nb_idx;
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                EMIT: begin
                    out_valid      <= 1'b0;
                    sort_done      <= 1'b0;
                    best_vld       <= 1'b0;
                    used[best_idx] <= 1'b1;
                    if (last_emit) begin
                        vld      <= '0;
                        used     <= '0;
                        fill_cnt <= '0;
                        emit_cnt <= '0;
                    end else begin
                        emit_cnt <= emit_cnt + (IDX_W+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ise_sort_sched.sv
// Scoreboard bench for ise_sort_sched: a reference sort of the loaded table
// produces the expected emission order, checked by an independent monitor.
`timescale 1ns/1ps
module tb_ise_sort_sched;

    localparam int NUM   = 32;
    localparam int IDX_W = 5;
    localparam int KEY_W = 15;
    localparam int KMAX  = (1 << KEY_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             rec_valid;
    logic [IDX_W-1:0] rec_index;
    logic [1:0]       rec_color;
    logic [KEY_W-1:0] rec_key;
    logic             rec_ready;
    logic             busy;
    logic             out_valid;
    logic [1:0]       color_index;
    logic [IDX_W-1:0] image_out_index;
    logic             sort_done;

    ise_sort_sched #(.NUM(NUM), .IDX_W(IDX_W), .KEY_W(KEY_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .rec_valid       (rec_valid),
        .rec_index       (rec_index),
        .rec_color       (rec_color),
        .rec_key         (rec_key),
        .rec_ready       (rec_ready),
        .busy            (busy),
        .out_valid       (out_valid),
        .color_index     (color_index),
        .image_out_index (image_out_index),
        .sort_done       (sort_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int color;
        int key;
    } rec_t;

    typedef struct {
        int color;
        int idx;
        bit done;
        bit first;
        int e0;
    } exp_t;

    rec_t pend[$];
    exp_t sb[$];
    int   mcolor [NUM];
    int   mkey   [NUM];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_cyc = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every negedge is one cycle; pulses are matched against the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        cyc++;
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: idx %0d colour %0d, expected no output (cycle %0d)",
                         image_out_index, color_index, cyc);
            end else begin
                e = sb.pop_front();
                chk("color_index", int'(color_index), e.color);
                chk("image_out_index", int'(image_out_index), e.idx);
                chk("sort_done", int'(sort_done), int'(e.done));
                if (e.first) chk("first_latency", cyc - e.e0, NUM + 1);
                else         chk("pulse_spacing", cyc - last_cyc, NUM + 1);
                last_cyc = cyc;
            end
        end else if (sort_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL sort_done_alone: got 1 without out_valid, expected 0 (cycle %0d)", cyc);
        end
    end

    task automatic add_rec(input int idx, input int color, input int key);
        rec_t r;
        r.idx = idx;
        r.color = color;
        r.key = key;
        pend.push_back(r);
    endtask

    // Random permutation of all indices, with one duplicate inserted mid-stream.
    task automatic make_random(input int cmax);
        int perm [NUM];
        int j, tmp;
        for (int i = 0; i < NUM; i++) perm[i] = i;
        for (int i = NUM - 1; i > 0; i--) begin
            j = int'($urandom_range(i));
            tmp = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int k = 0; k < NUM; k++) begin
            add_rec(perm[k], int'($urandom_range(cmax)), int'($urandom_range(KMAX)));
            if (k == NUM / 2)
                add_rec(perm[$urandom_range(k)], int'($urandom_range(cmax)), int'($urandom_range(KMAX)));
        end
    endtask

    task automatic load_pend();
        int t;
        int e0;
        int ord[$];
        exp_t e;
        t = 0;
        while (!rec_ready && t < 4 * NUM * (NUM + 1)) begin
            @(posedge clk); #1;
            t++;
        end
        chk("ready_before_load", int'(rec_ready), 1);
        foreach (pend[i]) begin
            if (i != 0) begin
                @(posedge clk); #1;
            end
            if ($urandom_range(3) == 0) begin
                rec_valid = 1'b0;
                @(posedge clk); #1;
            end
            rec_valid = 1'b1;
            rec_index = IDX_W'(pend[i].idx);
            rec_color = 2'(pend[i].color);
            rec_key   = KEY_W'(pend[i].key);
            mcolor[pend[i].idx] = pend[i].color;
            mkey[pend[i].idx]   = pend[i].key;
        end
        @(posedge clk); #1;
        rec_valid = 1'b0;
        e0 = cyc;
        pend.delete();
        chk("busy_after_load", int'(busy), 1);
        chk("ready_after_load", int'(rec_ready), 0);
        for (int i = 0; i < NUM; i++)
            ord.push_back((mcolor[i] << (KEY_W + IDX_W)) | ((KMAX - mkey[i]) << IDX_W) | i);
        ord.sort();
        foreach (ord[k]) begin
            e.color = ord[k] >> (KEY_W + IDX_W);
            e.idx   = ord[k] & ((1 << IDX_W) - 1);
            e.done  = (k == NUM - 1);
            e.first = (k == 0);
            e.e0    = e0;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < NUM * (NUM + 1) + 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("run_complete_pending", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int p, t;
        reset     = 1'b1;
        rec_valid = 1'b0;
        rec_index = '0;
        rec_color = '0;
        rec_key   = '0;
        @(posedge clk); #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_sort_done", int'(sort_done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_color_index", int'(color_index), 0);
        chk("reset_image_out_index", int'(image_out_index), 0);
        chk("reset_rec_ready", int'(rec_ready), 1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Full sort with structured colours and keys
        for (int i = 0; i < NUM; i++) add_rec(i, i % 3, i * 100);
        load_pend();
        wait_drain();

        // Equal records loaded in reverse order resolve to ascending index
        for (int i = NUM - 1; i >= 0; i--) add_rec(i, 1, 500);
        load_pend();
        wait_drain();

        // Duplicate index: second write wins and does not count toward the fill
        add_rec(5, 0, 10);
        add_rec(5, 0, 9000);
        for (int i = 0; i < NUM; i++)
            if (i != 5) add_rec(i, 0, int'($urandom_range(8999)));
        load_pend();
        wait_drain();

        // Record presented during SCAN must be dropped
        make_random(2);
        load_pend();
        repeat (5) @(posedge clk);
        #1;
        rec_valid = 1'b1;
        rec_index = IDX_W'(7);
        rec_color = 2'd3;
        rec_key   = KEY_W'(KMAX);
        repeat (3) @(posedge clk);
        #1;
        rec_valid = 1'b0;
        wait_drain();

        // Colour 3 sorts after everything regardless of key
        add_rec(0, 3, KMAX);
        for (int i = 1; i < NUM; i++) add_rec(i, 2, int'($urandom_range(KMAX)));
        load_pend();
        wait_drain();

        // Reset after the 10th output, then a fresh run
        make_random(3);
        load_pend();
        p = 0;
        t = 0;
        while (p < 10 && t < 12 * (NUM + 1)) begin
            @(negedge clk);
            if (out_valid) p++;
            t++;
        end
        chk("pulses_before_reset", p, 10);
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        chk("post_reset_out_valid", int'(out_valid), 0);
        chk("post_reset_rec_ready", int'(rec_ready), 1);
        chk("post_reset_busy", int'(busy), 0);
        repeat (2 * (NUM + 1)) @(posedge clk);
        #1;
        make_random(3);
        load_pend();
        wait_drain();

        // Additional random runs with duplicates
        for (int r = 0; r < 2; r++) begin
            make_random(3);
            load_pend();
            wait_drain();
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
